// File: rtl/delta_controller_output_storer.sv
// Output storer: drains word_count 128-bit words from Output SRAM to DRAM as 32-bit lane writes.
// Optional macro OUTPUT_STORER_RELU_EN clamps negative lanes to zero on the DRAM write path.
module delta_controller_output_storer #(
  parameter int CNT_W       = 16,
  parameter int SRAM_STRIDE = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       output_start_address,
  output logic [31:0]       Output_SRAM_r_addr,
  output logic              Output_SRAM_r_en,
  input  logic [127:0]      Output_SRAM_r_d,
  input  logic              Output_SRAM_d_ready,
  output logic              DRAM_Write,
  output logic [31:0]       DRAM_Address,
  output logic [31:0]       DRAM_WriteData,
  input  logic              DRAM_WriteDone,
  output logic              busy,
  output logic              finished
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_SRAM_RD, S_WR0, S_WR1, S_WR2, S_WR3, S_IDX_INC, S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_word_idx;
  logic [31:0]       r_sram_addr;
  logic [31:0]       r_dram_addr;
  logic [127:0]      r_data;
  logic [31:0]       w_lane;
  logic              w_wr_state;

  assign w_wr_state = (r_state == S_WR0) || (r_state == S_WR1) ||
                      (r_state == S_WR2) || (r_state == S_WR3);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_sram_addr <= '0;
      r_dram_addr <= '0;
      r_data      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count     <= word_count;
            r_dram_addr <= output_start_address;
            r_word_idx  <= '0;
            r_sram_addr <= '0;
          end
        end
        S_SRAM_RD: begin
          if (Output_SRAM_d_ready) r_data <= Output_SRAM_r_d;
        end
        S_WR0, S_WR1, S_WR2, S_WR3: begin
          if (DRAM_WriteDone) r_dram_addr <= r_dram_addr + 32'd4;
        end
        S_IDX_INC: begin
          r_word_idx  <= r_word_idx + 1'b1;
          r_sram_addr <= r_sram_addr + 32'(SRAM_STRIDE);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      S_WR0:   w_lane = r_data[31:0];
      S_WR1:   w_lane = r_data[63:32];
      S_WR2:   w_lane = r_data[95:64];
      S_WR3:   w_lane = r_data[127:96];
      default: w_lane = '0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next             = r_state;
    Output_SRAM_r_en   = 1'b0;
    Output_SRAM_r_addr = '0;
    DRAM_Write         = 1'b0;
    DRAM_Address       = '0;
    DRAM_WriteData     = '0;
    finished           = 1'b0;
    busy               = (r_state != S_IDLE);

    if (w_wr_state) begin
      DRAM_Write   = 1'b1;
      DRAM_Address = r_dram_addr;
`ifdef OUTPUT_STORER_RELU_EN
      DRAM_WriteData = w_lane[31] ? 32'd0 : w_lane;
`else
      DRAM_WriteData = w_lane;
`endif
    end

    case (r_state)
      S_IDLE:    if (start) w_next = S_CHECK;
      S_CHECK:   w_next = (r_word_idx == r_count) ? S_FINISH : S_SRAM_RD;
      S_SRAM_RD: begin
        Output_SRAM_r_en   = 1'b1;
        Output_SRAM_r_addr = r_sram_addr;
        if (Output_SRAM_d_ready) w_next = S_WR0;
      end
      S_WR0:     if (DRAM_WriteDone) w_next = S_WR1;
      S_WR1:     if (DRAM_WriteDone) w_next = S_WR2;
      S_WR2:     if (DRAM_WriteDone) w_next = S_WR3;
      S_WR3:     if (DRAM_WriteDone) w_next = S_IDX_INC;
      S_IDX_INC: w_next = S_CHECK;
      S_FINISH: begin
        finished = 1'b1;
        w_next   = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/delta_controller_output_storer.md
Name: delta_controller_output_storer

Overview:
- Downstream counterpart of the input loader. It drains computed results from the Output SRAM to DRAM.
- On `start`, it reads `word_count` 128-bit words from Output SRAM, starting at SRAM address 0 with a stride of 8 per word.
- Each word is split into four 32-bit DRAM writes at consecutive addresses from `output_start_address`, incrementing by 4 per lane.
- Sits between the Output SRAM and the DRAM port and is sequenced by the top-level Delta controller.

Parameters:
- CNT_W, 16, width of the word counter and of `word_count`.
- SRAM_STRIDE, 8, SRAM address increment per 128-bit word.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a store job; sampled only in IDLE.
- word_count  in  CNT_W  number of 128-bit words to store; latched on accepted start.
- output_start_address  in  32  DRAM byte address of the first lane; latched on accepted start.
- Output_SRAM_r_addr  out  32  SRAM read address.
- Output_SRAM_r_en  out  1  SRAM read request.
- Output_SRAM_r_d  in  128  SRAM read data.
- Output_SRAM_d_ready  in  1  read data valid this cycle.
- DRAM_Write  out  1  DRAM write request.
- DRAM_Address  out  32  DRAM write address.
- DRAM_WriteData  out  32  DRAM write data.
- DRAM_WriteDone  in  1  DRAM accepted the current write.
- busy  out  1  high in every state except IDLE.
- finished  out  1  one-cycle completion pulse.

Behaviour:
- Reset (sync, active-high):
  - state goes to IDLE; word counter, SRAM address and data register clear to 0; DRAM address register clears to 0.
  - All outputs are 0 on the cycle after reset is sampled.
  - Reset mid-job aborts immediately; no further DRAM writes are issued.
- States: IDLE, CHECK, SRAM_RD, WR0, WR1, WR2, WR3, IDX_INC, FINISH.
- IDLE:
  - With `start`=1: latch `word_count` and `output_start_address`, clear the word counter and SRAM address, go to CHECK.
  - Otherwise stay in IDLE.
- CHECK: go to FINISH if word counter == latched count (this includes count 0); else go to SRAM_RD.
- SRAM_RD:
  - `Output_SRAM_r_en`=1 and `Output_SRAM_r_addr` = SRAM address register.
  - On the cycle `Output_SRAM_d_ready`=1, capture `Output_SRAM_r_d` into the 128-bit data register and go to WR0; otherwise stay.
- WRk (k = 0..3):
  - `DRAM_Write`=1, `DRAM_Address` = DRAM address register, `DRAM_WriteData` = data[32k+31:32k].
  - Lane 0 ([31:0]) is written first.
  - On `DRAM_WriteDone`=1: DRAM address += 4 (registered); go to WR(k+1), or to IDX_INC from WR3. The next lane is driven the following cycle with no idle gap.
  - Otherwise hold all outputs stable.
- IDX_INC: word counter += 1, SRAM address += SRAM_STRIDE, go to CHECK.
- FINISH: `finished`=1 for exactly one cycle, then go to IDLE.
- Handshake rules:
  - `DRAM_WriteDone` is ignored unless `DRAM_Write`=1.
  - `Output_SRAM_d_ready` is ignored unless `Output_SRAM_r_en`=1.
  - `start` is ignored while `busy`=1.
- Arithmetic:
  - Address registers are 32-bit and wrap modulo 2^32 with no error.
  - Counter comparison is unsigned CNT_W-bit.
- Latency:
  - With zero-wait responders, a job takes 1 (CHECK) + 1 (SRAM_RD) + 4 (WR) + 1 (IDX_INC) = 7 cycles per word.
  - Add 1 final CHECK and 1 FINISH cycle.
  - `finished` is high 2 + 7N cycles after the start-accept edge.
- `start` in the same cycle as FINISH is ignored; it is accepted the next cycle, in IDLE.

Optional Feature:
- Macro: OUTPUT_STORER_RELU_EN.
- Defined: each 32-bit lane is clamped to 0 when bit 31 is set (signed negative) before it is driven on `DRAM_WriteData`. The clamp is combinational on the write path; there is no extra latency and the captured data register is unmodified.
- Undefined: lanes pass through unchanged.

Test Plan:
- Reset with random inputs toggling -> all outputs 0 and `busy`=0; `start`=1 held during reset -> no job started.
- `word_count`=1, `output_start_address`=0x1000, zero-wait responders, SRAM word 0x44444444_33333333_22222222_11111111 -> writes (0x1000,0x11111111), (0x1004,0x22222222), (0x1008,0x33333333), (0x100C,0x44444444) -> `finished` 9 cycles after accept.
- `word_count`=0 -> no SRAM read, no DRAM write, `finished` 2 cycles after accept.
- `word_count`=3, `DRAM_WriteDone` delayed 3 cycles per write, `d_ready` delayed 2 cycles -> SRAM reads at 0, 8, 16; 12 DRAM writes at 0x1000..0x102C in order; outputs stable during stalls.
- `start` pulsed mid-job, and reset asserted during WR2 of word 1 -> extra start ignored; after reset, no further writes and the block is IDLE; a new job then runs from its fresh start address.
- OUTPUT_STORER_RELU_EN defined, lanes {0x80000001, 0x7FFFFFFF, 0xFFFFFFFF, 0} -> written {0, 0x7FFFFFFF, 0, 0}; undefined -> written unchanged.
